// File: rtl/ssram_pkg.sv
// Shared encodings and idle pin values for the pipelined SSRAM bus responder.
package ssram_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    WR      = 2'b01,
    RD_WAIT = 2'b10,
    HOLD    = 2'b11
  } state_t;

  localparam int          SRAM_DATA_W = 32;
  localparam int          CNT_W       = 3;
  localparam logic [3:0]  BWE_IDLE    = 4'hf;

endpackage

// File: rtl/ssram_controller.sv
// Single-word bus responder for a 1M x 32 pipelined SSRAM: owns pin timing and read latency.
module ssram_controller
  import ssram_pkg::*;
#(
  parameter int ADDR_W       = 20,
  parameter int READ_LATENCY = 2   // legal range 1..4
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   select,
  input  logic                   start,
  input  logic                   read,
  input  logic                   write,
  input  logic [31:0]            address,
  input  logic [3:0]             be,
  input  logic [31:0]            writedata,
  output logic [31:0]            readdata,
  output logic                   ready,
  output logic [ADDR_W-1:0]      sram_addr,
  output logic                   sram_adsc_n,
  output logic                   sram_adsp_n,
  output logic                   sram_adv_n,
  output logic                   sram_ce_n,
  output logic                   sram_oe_n,
  output logic                   sram_we_n,
  output logic [3:0]             sram_bwe_n,
  output logic [SRAM_DATA_W-1:0] sram_dq_o,
  output logic                   sram_dq_oe,
  input  logic [SRAM_DATA_W-1:0] sram_dq_i
);

  state_t                 state_q;
  logic [CNT_W-1:0]       cnt_q;
  logic                   ready_q;
  logic [31:0]            readdata_q;
  logic [ADDR_W-1:0]      addr_q;
  logic                   adsc_n_q;
  logic                   ce_n_q;
  logic                   oe_n_q;
  logic                   we_n_q;
  logic [3:0]             bwe_n_q;
  logic [SRAM_DATA_W-1:0] dq_o_q;
  logic                   dq_oe_q;

  logic go;
  logic unused_addr_hi;

  assign go             = select && start && (read || write);
  assign unused_addr_hi = ^address[31:ADDR_W];

  // NOTE: every register here uses non-blocking assignment so all state updates
  // see pre-edge values; blocking would create order-dependent simulation races.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      ready_q    <= 1'b0;
      readdata_q <= '0;
      addr_q     <= '0;
      adsc_n_q   <= 1'b1;
      ce_n_q     <= 1'b1;
      oe_n_q     <= 1'b1;
      we_n_q     <= 1'b1;
      bwe_n_q    <= BWE_IDLE;
      dq_o_q     <= '0;
      dq_oe_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (go) begin
            addr_q   <= address[ADDR_W-1:0];
            adsc_n_q <= 1'b0;
            ce_n_q   <= 1'b0;
            // A simultaneous read and write request is serviced as a write.
            if (write) begin
              we_n_q  <= 1'b0;
              bwe_n_q <= ~be;
              dq_o_q  <= writedata;
              dq_oe_q <= 1'b1;
              state_q <= WR;
            end else begin
              oe_n_q  <= 1'b0;
              cnt_q   <= CNT_W'(READ_LATENCY);
              state_q <= RD_WAIT;
            end
          end
        end
        WR: begin
          adsc_n_q <= 1'b1;
          ce_n_q   <= 1'b1;
          we_n_q   <= 1'b1;
          bwe_n_q  <= BWE_IDLE;
          dq_oe_q  <= 1'b0;
          ready_q  <= 1'b1;
          state_q  <= HOLD;
        end
        RD_WAIT: begin
          adsc_n_q <= 1'b1;
          ce_n_q   <= 1'b1;
          if (cnt_q == '0) begin
            // The pipeline always drains; an aborted read still captures data.
            readdata_q <= sram_dq_i;
            oe_n_q     <= 1'b1;
            if (read) begin
              ready_q <= 1'b1;
              state_q <= HOLD;
            end else begin
              state_q <= IDLE;
            end
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        HOLD: begin
          if (!(read || write)) begin
            ready_q <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ready       = ready_q & select;
  assign readdata    = readdata_q;
  assign sram_addr   = addr_q;
  assign sram_adsc_n = adsc_n_q;
  assign sram_adsp_n = 1'b1;
  assign sram_adv_n  = 1'b1;
  assign sram_ce_n   = ce_n_q;
  assign sram_oe_n   = oe_n_q;
  assign sram_we_n   = we_n_q;
  assign sram_bwe_n  = bwe_n_q;
  assign sram_dq_o   = dq_o_q;
  assign sram_dq_oe  = dq_oe_q;

endmodule

// File: doc/ssram_controller.md
Name: ssram_controller

Overview:
- Bus responder for the 1M x 32 pipelined synchronous SRAM. It occupies chipselect bit 0 of the system bus.
- Accepts single-word read/write transactions from the bus controller and sequences the SSRAM control pins. It returns read data and a registered ready to the master.
- Owns the SSRAM pin timing so the bus controller no longer has to hard-code SRAM latency.

Parameters:
- ADDR_W, 20, SSRAM word-address width (bus address is a word address).
- READ_LATENCY, 2, SSRAM clocks from address sample to data valid; legal range 1..4.

Ports:
- clock  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- select  in  1  chipselect bit for this device
- start  in  1  one-cycle pulse marking the start of a bus transaction
- read  in  1  read request, held by master until it ends the transaction
- write  in  1  write request, held likewise
- address  in  32  bus word address; bits [ADDR_W-1:0] used
- be  in  4  byte enables, active high
- writedata  in  32  write data
- readdata  out  32  captured read data, held until next read capture
- ready  out  1  transaction complete, master may drop request
- sram_addr  out  ADDR_W  SSRAM address
- sram_adsc_n  out  1  address strobe, active low
- sram_adsp_n  out  1  constant 1
- sram_adv_n  out  1  constant 1 (no burst)
- sram_ce_n  out  1  chip enable, active low
- sram_oe_n  out  1  output enable, active low
- sram_we_n  out  1  byte-write enable, active low
- sram_bwe_n  out  4  byte lane writes, active low
- sram_dq_o  out  32  data to SSRAM
- sram_dq_oe  out  1  drive dq_o onto pad (tristate lives at top level)
- sram_dq_i  in  32  data from SSRAM pad

Behaviour:
- All SSRAM pin outputs, readdata and the internal ready register are registered.
- Reset (async, immediate, including mid-transaction):
  - readdata=0, ready=0, sram_addr=0, sram_dq_o=0, sram_dq_oe=0.
  - adsc_n=1, ce_n=1, oe_n=1, we_n=1, bwe_n=4'hf.
  - State goes to IDLE and the latency counter to 0.
- ready output = ready_reg & select.
- States: IDLE, WR, RD_WAIT, HOLD.
- Cycle 0 is the cycle in which select & start & (read|write) is seen in IDLE. start is ignored in any other state.
- If read and write are both high, write wins.
- Write:
  - Edge E0 → WR. During cycle 1: sram_addr=address[ADDR_W-1:0], adsc_n=0, ce_n=0, we_n=0, bwe_n=~be, dq_o=writedata, dq_oe=1.
  - E1 → HOLD. Pins return to idle values (dq_oe=0) and ready_reg=1, so ready is high from cycle 2.
- Read:
  - E0 → RD_WAIT with cnt=READ_LATENCY. During cycle 1: sram_addr set, adsc_n=0, ce_n=0, oe_n=0, we_n=1.
  - From cycle 2: adsc_n=1, ce_n=1. oe_n stays 0 through the capture cycle.
  - In RD_WAIT, cnt decrements each cycle. On the edge ending the cycle with cnt==0: readdata<=sram_dq_i, oe_n<=1.
  - Then → HOLD with ready_reg=1 if read is still high, else → IDLE with ready_reg=0.
  - ready is first high in cycle READ_LATENCY+2 (cycle 4 at default).
- HOLD: stay while (read|write) is high. When both are low, next edge → IDLE with ready_reg=0.
- Abort: read dropped during RD_WAIT.
  - The pipeline still completes and readdata is still updated.
  - ready is never asserted.
  - The block returns to IDLE after the capture edge.
- Master protocol guarantee: no new start arrives until ready has fallen or the abort has drained. A start arriving outside IDLE is dropped; the bench flags it with an assertion.
- No write-after-read turnaround hazard exists, because every transaction returns through IDLE, which leaves at least one cycle with dq_oe=0.

Decomposition:
- Shared package ssram_pkg holds:
  - state encoding localparams: IDLE=2'b00, WR=2'b01, RD_WAIT=2'b10, HOLD=2'b11;
  - SRAM_DATA_W=32;
  - idle pin values (BWE_IDLE=4'hf).
- No sub-module: the FSM, counter and pin registers form one unit.
- The tristate buffer is instantiated in the top level, not here.

Test Plan:
- Reset: hold reset_n low, drive random inputs → every output at its reset value; adsp_n=adv_n=1 always.
- Write: address 0x00012345, writedata 0xdeadbeef, be 4'b0011, start → cycle 1 sram_addr 0x12345, we_n 0, bwe_n 4'b1100, dq_oe 1; ready high cycle 2; drop write in cycle 3 → ready 0 in cycle 4, state IDLE.
- Read (SSRAM model latency 2 returns 0xcafef00d at 0x12345): oe_n low cycles 1-3, ready high cycle 4, readdata 0xcafef00d; repeat with READ_LATENCY=4 → ready cycle 6.
- Abort: drop read in cycle 2 → ready never high, IDLE by cycle 4; a new write started in cycle 5 completes normally (ready in cycle 7).
- select=0 with start and read → no pin activity and ready stays 0. read=write=1 with start → write cycle on pins.
- Async reset asserted mid-cycle during RD_WAIT → pins idle immediately without a clock edge; after release, a read completes with the correct data.
